// File: rtl/arith_pkg.sv
// arith_pkg: shared op codes, beat result width and accumulator state encoding
package arith_pkg;
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_ADD = 1'b1;
  localparam int RES_W = 6;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
endpackage

// File: rtl/arith_result_accumulator_if.sv
// arith_result_accumulator_if: operand-beat input channel and group-total output channel, each valid/ready
interface arith_result_accumulator_if #(
  parameter int ACC_W = 12,
  parameter int CNT_W = 4
);
  logic in_valid;
  logic in_ready;
  logic in_sel;
  logic [2:0] in_a;
  logic [2:0] in_b;
  logic in_last;
  logic out_valid;
  logic out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_count;
  logic out_ovf;
  modport master (
    output in_valid, in_sel, in_a, in_b, in_last, out_ready,
    input in_ready, out_valid, out_acc, out_count, out_ovf
  );
  modport slave (
    input in_valid, in_sel, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_ovf
  );
endinterface

// File: rtl/arith_unit_3bit.sv
// arith_unit_3bit: combinational 3-bit add (sel_i=1) or multiply (sel_i=0) giving a 6-bit result r_o
module arith_unit_3bit
  import arith_pkg::*;
(
  input  logic [2:0]       a_i,
  input  logic [2:0]       b_i,
  input  logic             sel_i,
  output logic [RES_W-1:0] r_o
);
  always_comb r_o = (sel_i == OP_ADD) ? RES_W'(a_i) + RES_W'(b_i) : RES_W'(a_i) * RES_W'(b_i);
endmodule

// File: rtl/arith_result_accumulator.sv
// arith_result_accumulator: registers beat results and sums each group into a saturating total (clk, rst, bus: slave side of in/out handshakes)
module arith_result_accumulator
  import arith_pkg::*;
#(
  parameter int ACC_W = 12,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic rst,
  arith_result_accumulator_if.slave bus
);
  localparam logic [CNT_W:0] AUTO_AHEAD = (CNT_W+1)'((1 << CNT_W) - 2);
  state_t state_q;
  logic p_valid_q, p_last_q;
  logic [RES_W-1:0] p_r_q, r;
  logic [ACC_W-1:0] acc_q, acc_d, out_acc_q;
  logic [CNT_W-1:0] count_q, count_d, out_count_q;
  logic ovf_q, ovf_d, out_valid_q, out_ovf_q;
  logic [ACC_W:0] sum;
  logic accept, auto_last;
  arith_unit_3bit u_alu (.a_i(bus.in_a), .b_i(bus.in_b), .sel_i(bus.in_sel), .r_o(r));
  assign bus.in_ready = !rst && state_q != HOLD && !(p_valid_q && p_last_q);
  assign accept = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_acc = out_acc_q;
  assign bus.out_count = out_count_q;
  assign bus.out_ovf = out_ovf_q;
  always_comb begin
    // the beat in P counts as already taken, so the incoming beat is the auto-closing one
    // when count plus P would leave it as the (2^CNT_W-1)th beat
    auto_last = ({1'b0, count_q} + (CNT_W+1)'(p_valid_q)) == AUTO_AHEAD;
    sum = {1'b0, acc_q} + (ACC_W+1)'(p_r_q);
    acc_d = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
    ovf_d = ovf_q | sum[ACC_W];
    count_d = count_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      p_valid_q <= 1'b0;
      p_last_q <= 1'b0;
      p_r_q <= '0;
      acc_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q <= '0;
      out_count_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      p_valid_q <= accept;
      if (accept) begin
        p_r_q <= r;
        p_last_q <= bus.in_last | auto_last;
      end
      case (state_q)
        IDLE, ACCUM: if (p_valid_q) begin
          acc_q <= acc_d;
          count_q <= count_d;
          ovf_q <= ovf_d;
          state_q <= p_last_q ? HOLD : ACCUM;
          if (p_last_q) begin
            out_valid_q <= 1'b1;
            out_acc_q <= acc_d;
            out_count_q <= count_d;
            out_ovf_q <= ovf_d;
          end
        end
        HOLD: if (bus.out_ready) begin
          state_q <= IDLE;
          acc_q <= '0;
          count_q <= '0;
          ovf_q <= 1'b0;
          out_valid_q <= 1'b0;
          out_acc_q <= '0;
          out_count_q <= '0;
          out_ovf_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_arith_result_accumulator.sv
// tb_arith_result_accumulator: directed self-checking bench for arith_result_accumulator with ACC_W=8
module tb_arith_result_accumulator;
  import arith_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  arith_result_accumulator_if #(.ACC_W(8), .CNT_W(4)) bus ();
  arith_result_accumulator #(.ACC_W(8), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic sel, input logic [2:0] a, input logic [2:0] b, input logic last);
    bus.in_valid = 1'b1;
    bus.in_sel = sel;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_last = last;
  endtask

  task automatic drain;
    bus.out_ready = 1'b1;
    step;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    step;
    step;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b want=0", bus.out_valid); end
    total++; if (bus.out_acc !== 8'd0) begin bad++; $display("FAIL rst_acc got=%0d want=0", bus.out_acc); end
    total++; if (bus.out_count !== 4'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", bus.out_count); end
    total++; if (bus.out_ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%0b want=0", bus.out_ovf); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b want=0", bus.in_ready); end
    rst = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%0b want=1", bus.in_ready); end
  endtask

  task automatic test_single_mul;
    offer(OP_MUL, 3'd7, 3'd5, 1'b1);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mul_ready got=%0b want=1", bus.in_ready); end
    step;
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mul_early_valid got=%0b want=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL mul_p_ready got=%0b want=0", bus.in_ready); end
    step;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL mul_valid got=%0b want=1", bus.out_valid); end
    total++; if (bus.out_acc !== 8'd35) begin bad++; $display("FAIL mul_acc got=%0d want=35", bus.out_acc); end
    total++; if (bus.out_count !== 4'd1) begin bad++; $display("FAIL mul_count got=%0d want=1", bus.out_count); end
    total++; if (bus.out_ovf !== 1'b0) begin bad++; $display("FAIL mul_ovf got=%0b want=0", bus.out_ovf); end
    drain;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mul_drain_valid got=%0b want=0", bus.out_valid); end
    total++; if (bus.out_acc !== 8'd0) begin bad++; $display("FAIL mul_drain_acc got=%0d want=0", bus.out_acc); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mul_drain_ready got=%0b want=1", bus.in_ready); end
  endtask

  task automatic test_back_to_back;
    logic [2:0] av [3] = '{3'd3, 3'd7, 3'd1};
    logic [2:0] bv [3] = '{3'd4, 3'd7, 3'd0};
    for (int i = 0; i < 3; i++) begin
      offer(OP_ADD, av[i], bv[i], i == 2);
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready beat=%0d got=%0b want=1", i, bus.in_ready); end
      step;
    end
    bus.in_valid = 1'b0;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_last_ready got=%0b want=0", bus.in_ready); end
    step;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%0b want=1", bus.out_valid); end
    total++; if (bus.out_acc !== 8'd22) begin bad++; $display("FAIL b2b_acc got=%0d want=22", bus.out_acc); end
    total++; if (bus.out_count !== 4'd3) begin bad++; $display("FAIL b2b_count got=%0d want=3", bus.out_count); end
    drain;
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 6; i++) begin
      offer(OP_MUL, 3'd7, 3'd7, i == 5);
      step;
    end
    bus.in_valid = 1'b0;
    step;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL sat_valid got=%0b want=1", bus.out_valid); end
    total++; if (bus.out_acc !== 8'd255) begin bad++; $display("FAIL sat_acc got=%0d want=255", bus.out_acc); end
    total++; if (bus.out_ovf !== 1'b1) begin bad++; $display("FAIL sat_ovf got=%0b want=1", bus.out_ovf); end
    total++; if (bus.out_count !== 4'd6) begin bad++; $display("FAIL sat_count got=%0d want=6", bus.out_count); end
    drain;
    total++; if (bus.out_ovf !== 1'b0) begin bad++; $display("FAIL sat_drain_ovf got=%0b want=0", bus.out_ovf); end
    offer(OP_MUL, 3'd2, 3'd3, 1'b1);
    step;
    bus.in_valid = 1'b0;
    step;
    total++; if (bus.out_acc !== 8'd6) begin bad++; $display("FAIL sat_next_acc got=%0d want=6", bus.out_acc); end
    total++; if (bus.out_ovf !== 1'b0) begin bad++; $display("FAIL sat_next_ovf got=%0b want=0", bus.out_ovf); end
    total++; if (bus.out_count !== 4'd1) begin bad++; $display("FAIL sat_next_count got=%0d want=1", bus.out_count); end
    drain;
  endtask

  task automatic test_auto_close;
    for (int i = 0; i < 15; i++) begin
      offer(OP_ADD, 3'd1, 3'd1, 1'b0);
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL auto_ready beat=%0d got=%0b want=1", i, bus.in_ready); end
      step;
    end
    offer(OP_MUL, 3'd3, 3'd3, 1'b1);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL auto_16th_ready got=%0b want=0", bus.in_ready); end
    step;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL auto_valid got=%0b want=1", bus.out_valid); end
    total++; if (bus.out_acc !== 8'd30) begin bad++; $display("FAIL auto_acc got=%0d want=30", bus.out_acc); end
    total++; if (bus.out_count !== 4'd15) begin bad++; $display("FAIL auto_count got=%0d want=15", bus.out_count); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL auto_hold_ready got=%0b want=0", bus.in_ready); end
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 5; i++) begin
      step;
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d got=%0b want=1", i, bus.out_valid); end
      total++; if (bus.out_acc !== 8'd30) begin bad++; $display("FAIL bp_acc cyc=%0d got=%0d want=30", i, bus.out_acc); end
      total++; if (bus.out_count !== 4'd15) begin bad++; $display("FAIL bp_count cyc=%0d got=%0d want=15", i, bus.out_count); end
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready cyc=%0d got=%0b want=0", i, bus.in_ready); end
    end
    drain;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain_valid got=%0b want=0", bus.out_valid); end
    total++; if (bus.out_count !== 4'd0) begin bad++; $display("FAIL bp_drain_count got=%0d want=0", bus.out_count); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_drain_ready got=%0b want=1", bus.in_ready); end
    step;
    bus.in_valid = 1'b0;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_pending_taken got=%0b want=0", bus.in_ready); end
    step;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_next_valid got=%0b want=1", bus.out_valid); end
    total++; if (bus.out_acc !== 8'd9) begin bad++; $display("FAIL bp_next_acc got=%0d want=9", bus.out_acc); end
    total++; if (bus.out_count !== 4'd1) begin bad++; $display("FAIL bp_next_count got=%0d want=1", bus.out_count); end
    drain;
  endtask

  task automatic test_reset_mid;
    offer(OP_MUL, 3'd2, 3'd3, 1'b0);
    step;
    step;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rmid_rst_ready got=%0b want=0", bus.in_ready); end
    step;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid cyc=%0d got=%0b want=0", i, bus.out_valid); end
      total++; if (bus.out_acc !== 8'd0) begin bad++; $display("FAIL rmid_acc cyc=%0d got=%0d want=0", i, bus.out_acc); end
      total++; if (bus.out_count !== 4'd0) begin bad++; $display("FAIL rmid_count cyc=%0d got=%0d want=0", i, bus.out_count); end
      step;
    end
    offer(OP_MUL, 3'd2, 3'd2, 1'b1);
    step;
    bus.in_valid = 1'b0;
    step;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rmid_next_valid got=%0b want=1", bus.out_valid); end
    total++; if (bus.out_acc !== 8'd4) begin bad++; $display("FAIL rmid_next_acc got=%0d want=4", bus.out_acc); end
    total++; if (bus.out_count !== 4'd1) begin bad++; $display("FAIL rmid_next_count got=%0d want=1", bus.out_count); end
    drain;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sel = OP_ADD;
    bus.in_a = 3'd0;
    bus.in_b = 3'd0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    test_reset;
    test_single_mul;
    test_back_to_back;
    test_saturation;
    test_auto_close;
    test_backpressure;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
